rate_pulse_gen: RTL and testbench

RATE_PULSE_GEN -- requirements
Module: rate_pulse_gen

---
 rtl/rate_pulse_gen.sv | 88 ++++++++
 tb/tb_rate_pulse_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rate_pulse_gen.sv
// Per-channel programmable rate strobes; optional one-shot mode under RATE_PULSE_GEN_ONESHOT_EN.
// Latency: pulse registered, first strobe on the (tc+1)th enabled edge; no backpressure, strobes are fire-and-forget.
module rate_pulse_gen #(
  parameter int unsigned CLK_SPEED_HZ = 100_000_000,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DEFAULT_FPS  = 1,
  parameter int unsigned CNT_W        = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_tc,
`ifdef RATE_PULSE_GEN_ONESHOT_EN
  input  logic [NUM_CH-1:0] oneshot,
  output logic [NUM_CH-1:0] done,
`endif
  output logic [NUM_CH-1:0] pulse
);

  localparam longint unsigned DEF_TC_W = 64'(CLK_SPEED_HZ / DEFAULT_FPS) - 64'd1;
  localparam logic [CNT_W-1:0] DEF_TC  = CNT_W'(DEF_TC_W);

  // A too-slow default rate (or DEFAULT_FPS above the clock) must not silently wrap.
  if (DEF_TC_W >= (64'd1 << CNT_W)) begin : g_bad_def_tc
    $error("rate_pulse_gen: default terminal count does not fit CNT_W bits");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("rate_pulse_gen: NUM_CH must be 1..16");
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] tc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pulse_q;
    logic             wr_hit;
    logic             freeze;

    assign wr_hit = cfg_wr && (cfg_ch == 4'(g));

`ifdef RATE_PULSE_GEN_ONESHOT_EN
    logic done_q;

    // The strobe edge of a one-shot channel is followed by the done edge; after that it stays parked.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        done_q <= 1'b0;
      end else if (wr_hit || sync_clr || !en[g]) begin
        done_q <= 1'b0;
      end else if (oneshot[g] && pulse_q) begin
        done_q <= 1'b1;
      end
    end

    assign freeze  = done_q || (oneshot[g] && pulse_q);
    assign done[g] = done_q;
`else
    assign freeze = 1'b0;
`endif

    // Write clears the counter so a lowered tc can never leave cnt above it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tc_q    <= DEF_TC;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else if (wr_hit) begin
        tc_q    <= cfg_tc;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else if (sync_clr || !en[g] || freeze) begin
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else if (cnt_q == tc_q) begin
        cnt_q   <= '0;
        pulse_q <= 1'b1;
      end else begin
        cnt_q   <= cnt_q + CNT_W'(1);
        pulse_q <= 1'b0;
      end
    end

    assign pulse[g] = pulse_q;
  end

endmodule

// File: tb/tb_rate_pulse_gen.sv
// Directed plus randomized check of rate_pulse_gen against an age-modulo reference model.
module tb_rate_pulse_gen;
  localparam int DEF_TC = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] en = 2'b11;
  logic       sync_clr = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [3:0] cfg_ch = 4'd0;
  logic [7:0] cfg_tc = 8'd0;
  logic [1:0] pulse;
`ifdef RATE_PULSE_GEN_ONESHOT_EN
  logic [1:0] oneshot = 2'b00;
  logic [1:0] done;
`endif

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  int m_tc[2];
  int m_start[2];
  logic [1:0] m_pulse;
  logic [1:0] m_done;

  rate_pulse_gen #(
    .CLK_SPEED_HZ(100),
    .NUM_CH(2),
    .DEFAULT_FPS(10),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .sync_clr(sync_clr),
    .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch),
    .cfg_tc(cfg_tc),
`ifdef RATE_PULSE_GEN_ONESHOT_EN
    .oneshot(oneshot),
    .done(done),
`endif
    .pulse(pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_tc[c]    = DEF_TC;
      m_start[c] = edge_n;
    end
    m_pulse = 2'b00;
    m_done  = 2'b00;
  endfunction

  // A channel's age is the number of edges since it was last restarted; it strobes at every multiple of tc+1.
  function automatic void model_edge();
    int age;
    logic os;
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < 2; c++) begin
      if (cfg_wr && int'(cfg_ch) == c) begin
        m_tc[c]    = int'(cfg_tc);
        m_start[c] = edge_n;
      end else if (sync_clr || !en[c]) begin
        m_start[c] = edge_n;
      end
      age = edge_n - m_start[c];
`ifdef RATE_PULSE_GEN_ONESHOT_EN
      os = oneshot[c];
`else
      os = 1'b0;
`endif
      if (age == 0) begin
        m_pulse[c] = 1'b0;
        m_done[c]  = 1'b0;
      end else if (os) begin
        m_pulse[c] = (age == m_tc[c] + 1);
        m_done[c]  = (age >= m_tc[c] + 2);
      end else begin
        m_pulse[c] = ((age % (m_tc[c] + 1)) == 0);
        m_done[c]  = 1'b0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    chk($sformatf("pulse_e%0d", edge_n), 32'(pulse), 32'(m_pulse));
`ifdef RATE_PULSE_GEN_ONESHOT_EN
    chk($sformatf("done_e%0d", edge_n), 32'(done), 32'(m_done));
`endif
  endtask

  initial begin
    int n0, n1, first1;
    bit found;

    // Reset asserts without a clock edge and holds outputs low
    #1 rst = 1'b1;
    #1 chk("reset_async", 32'(pulse), 32'd0);
    model_reset();
    repeat (3) tick();
    rst = 1'b0;

    // Default rate: tc=9, strobes on both channels at released edges 10, 20, 30
    n0 = 0; n1 = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      n0 += int'(pulse[0]);
      n1 += int'(pulse[1]);
      if (k == 9)  chk("pre_first_pulse", 32'(pulse), 32'd0);
      if (k == 10) chk("first_pulse", 32'(pulse), 32'd3);
    end
    chk("default_cnt0", 32'(n0), 32'd3);
    chk("default_cnt1", 32'(n1), 32'd3);

    // ch1 reprogrammed to period 4; ch0 keeps period 10
    cfg_wr = 1'b1; cfg_ch = 4'd1; cfg_tc = 8'd3;
    tick();
    cfg_wr = 1'b0;
    n0 = 0; n1 = 0; first1 = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n0 += int'(pulse[0]);
      n1 += int'(pulse[1]);
      if (pulse[1] && first1 < 0) first1 = k;
    end
    chk("ch1_first", 32'(first1), 32'd4);
    chk("ch1_cnt", 32'(n1), 32'd5);
    chk("ch0_cnt", 32'(n0), 32'd2);

    // Write lands on ch0's terminal edge: write wins, no strobe
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (((edge_n + 1 - m_start[0]) % (m_tc[0] + 1)) == 0) found = 1'b1;
      else tick();
    end
    chk("term_search", 32'(found), 32'd1);
    cfg_wr = 1'b1; cfg_ch = 4'd0; cfg_tc = 8'd5;
    tick();
    cfg_wr = 1'b0;
    chk("collide_no_pulse", 32'(pulse[0]), 32'd0);
    n0 = 0;
    repeat (5) begin
      tick();
      n0 += int'(pulse[0]);
    end
    chk("collide_quiet", 32'(n0), 32'd0);
    tick();
    chk("collide_next", 32'(pulse[0]), 32'd1);

    // Out-of-range channel index is ignored
    cfg_wr = 1'b1; cfg_ch = 4'd5; cfg_tc = 8'd0;
    tick();
    cfg_wr = 1'b0;
    repeat (12) tick();

    // tc=0 gives a continuous strobe while enabled
    cfg_wr = 1'b1; cfg_ch = 4'd0; cfg_tc = 8'd0;
    tick();
    cfg_wr = 1'b0;
    n0 = 0;
    repeat (8) begin
      tick();
      n0 += int'(pulse[0]);
    end
    chk("tc0_continuous", 32'(n0), 32'd8);
    en = 2'b10;
    tick();
    chk("en_low", 32'(pulse[0]), 32'd0);
    en = 2'b11;
    tick();
    chk("en_high_tc0", 32'(pulse[0]), 32'd1);

    // sync_clr re-phases both channels
    repeat ($urandom_range(1, 7)) tick();
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
    chk("sync_clr", 32'(pulse), 32'd0);
    first1 = -1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (pulse[1] && first1 < 0) first1 = k;
    end
    chk("sync_ch1_first", 32'(first1), 32'd4);

    // Reset between edges: immediate clear, tc back to default
    rst = 1'b1;
    #2 chk("rst_mid", 32'(pulse), 32'd0);
    model_reset();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 10) chk("rst_default_tc", 32'(pulse), 32'd3);
    end

    // Randomized traffic against the model
    repeat (400) begin
      en       = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      sync_clr = ($urandom_range(0, 29) == 0);
      cfg_wr   = ($urandom_range(0, 9) == 0);
      cfg_ch   = 4'($urandom_range(0, 6));
      cfg_tc   = 8'($urandom_range(0, 12));
      tick();
    end
    en = 2'b11; sync_clr = 1'b0; cfg_wr = 1'b0;

`ifdef RATE_PULSE_GEN_ONESHOT_EN
    // One-shot: single strobe at edge 5, done from edge 6, re-armed by en toggle
    oneshot = 2'b01;
    cfg_wr = 1'b1; cfg_ch = 4'd0; cfg_tc = 8'd4;
    tick();
    cfg_wr = 1'b0;
    n0 = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n0 += int'(pulse[0]);
      if (k == 5) chk("os_pulse", 32'(pulse[0]), 32'd1);
      if (k == 6) chk("os_done", 32'(done[0]), 32'd1);
    end
    chk("os_single", 32'(n0), 32'd1);
    en = 2'b10;
    tick();
    chk("os_rearm", 32'(done[0]), 32'd0);
    en = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 5) chk("os_again", 32'(pulse[0]), 32'd1);
    end
    repeat (6) tick();
    oneshot = 2'b00;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
